// File: rtl/ram_ctrl_pkg.sv
// rtl/ram_ctrl_pkg.sv - shared state and port-index definitions for the RAM write scheduler
package ram_ctrl_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  localparam int PORT_A = 0;
  localparam int PORT_B = 1;

endpackage

// File: rtl/rr_arbiter_2.sv
// rtl/rr_arbiter_2.sv - two-way round-robin grant with next last-served computation
module rr_arbiter_2
  import ram_ctrl_pkg::*;
(
  input  logic [1:0] req,
  input  logic       advance,
  input  logic       last_served,
  output logic [1:0] grant,
  output logic       last_served_next
);

  always_comb begin
    grant = req;
    // On contention favour whichever port did not win the previous transfer
    if (req == 2'b11) begin
      grant = 2'b00;
      if (last_served) grant[PORT_A] = 1'b1;
      else             grant[PORT_B] = 1'b1;
    end
  end

  always_comb begin
    last_served_next = last_served;
    if (advance) last_served_next = grant[PORT_B];
  end

endmodule

// File: rtl/ram_1w_1ra_write_scheduler.sv
// rtl/ram_1w_1ra_write_scheduler.sv - clears the RAM then arbitrates two write requesters onto one write port
module ram_1w_1ra_write_scheduler
  import ram_ctrl_pkg::*;
#(
  parameter int                   wordCount    = 16,
  parameter int                   wordWidth    = 32,
  parameter int                   addressWidth = 4,
  parameter logic [wordWidth-1:0] initValue    = '0
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    a_valid,
  output logic                    a_ready,
  input  logic [addressWidth-1:0] a_addr,
  input  logic [wordWidth-1:0]    a_data,
  input  logic                    b_valid,
  output logic                    b_ready,
  input  logic [addressWidth-1:0] b_addr,
  input  logic [wordWidth-1:0]    b_data,
  input  logic                    flush_req,
  output logic                    busy,
  output logic                    clear_done,
  output logic                    ram_wr_en,
  output logic [addressWidth-1:0] ram_wr_addr,
  output logic [wordWidth-1:0]    ram_wr_data
);

  localparam logic [addressWidth-1:0] LAST_ADDR = addressWidth'(wordCount - 1);

  state_e                  state_q, state_d;
  logic [addressWidth-1:0] clear_ptr_q, clear_ptr_d;
  logic                    last_q, last_d;
  logic                    wr_en_q, wr_en_d;
  logic [addressWidth-1:0] wr_addr_q, wr_addr_d;
  logic [wordWidth-1:0]    wr_data_q, wr_data_d;
  logic                    clear_done_q, clear_done_d;

  logic [1:0] grant;
  logic       accept_a, accept_b;
  logic       running;

  assign running  = (state_q == ST_RUN) && !flush_req;
  assign a_ready  = running && grant[PORT_A];
  assign b_ready  = running && grant[PORT_B];
  assign accept_a = a_ready && a_valid;
  assign accept_b = b_ready && b_valid;

  rr_arbiter_2 u_arb (
    .req              ({b_valid, a_valid}),
    .advance          (accept_a || accept_b),
    .last_served      (last_q),
    .grant            (grant),
    .last_served_next (last_d)
  );

  always_comb begin
    state_d      = state_q;
    clear_ptr_d  = clear_ptr_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    clear_done_d = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        wr_en_d   = 1'b1;
        wr_addr_d = clear_ptr_q;
        wr_data_d = initValue;
        if (clear_ptr_q == LAST_ADDR) begin
          clear_ptr_d  = '0;
          state_d      = ST_RUN;
          clear_done_d = 1'b1;
        end else begin
          clear_ptr_d = clear_ptr_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (flush_req) begin
          state_d = ST_CLEAR;
        end else if (accept_a) begin
          wr_en_d   = 1'b1;
          wr_addr_d = a_addr;
          wr_data_d = a_data;
        end else if (accept_b) begin
          wr_en_d   = 1'b1;
          wr_addr_d = b_addr;
          wr_data_d = b_data;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_CLEAR;
      clear_ptr_q  <= '0;
      last_q       <= 1'b1;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      clear_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      clear_ptr_q  <= clear_ptr_d;
      last_q       <= last_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      clear_done_q <= clear_done_d;
    end
  end

  assign busy        = (state_q == ST_CLEAR);
  assign clear_done  = clear_done_q;
  assign ram_wr_en   = wr_en_q;
  assign ram_wr_addr = wr_addr_q;
  assign ram_wr_data = wr_data_q;

endmodule

// File: doc/ram_1w_1ra_write_scheduler.md
RAM_1W_1RA_WRITE_SCHEDULER -- requirements
Module: ram_1w_1ra_write_scheduler

Interface
REQ-001 SHALL have parameter wordCount, default 16, number of RAM words; legal range 2..2**addressWidth.
REQ-002 SHALL have parameter wordWidth, default 32, RAM word width in bits.
REQ-003 SHALL have parameter addressWidth, default 4, RAM address width in bits.
REQ-004 SHALL have parameter initValue, default 0, wordWidth-bit value written to every word during a clear.
REQ-005 SHALL have ports: clk  in  1  sole clock, all logic on rising edge; resetn  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports: a_valid in 1, a_ready out 1, a_addr in addressWidth, a_data in wordWidth; requester A write channel.
REQ-007 SHALL have ports: b_valid in 1, b_ready out 1, b_addr in addressWidth, b_data in wordWidth; requester B write channel.
REQ-008 SHALL have ports: flush_req in 1, re-clear request; busy out 1, clear in progress; clear_done out 1, single-cycle pulse at clear completion.
REQ-009 SHALL have ports: ram_wr_en out 1, ram_wr_addr out addressWidth, ram_wr_data out wordWidth; drive the RAM write port directly.

Function
REQ-010 SHALL implement two states: CLEAR and RUN.
REQ-011 CLEAR: each cycle SHALL issue one write of initValue to clear_ptr, then increment clear_ptr; a_ready=b_ready=0; busy=1.
REQ-012 CLEAR SHALL exit to RUN after writing address wordCount-1, with clear_ptr back at 0 (no writes to addresses >= wordCount).
REQ-013 clear_done SHALL pulse high for exactly one cycle, the cycle after the final clear write is issued.
REQ-014 RUN: a transfer on a port SHALL occur when valid && ready in the same cycle.
REQ-015 ready SHALL be combinational: state==RUN && !flush_req && port holds the grant.
REQ-016 Grant: if only one port is valid it SHALL be granted; if both are valid, the port not served by the last accepted transfer is granted (round-robin).
REQ-017 The last-served pointer SHALL update only on an accepted transfer.
REQ-018 An accepted transfer SHALL appear on ram_wr_en/addr/data exactly 1 cycle later; all ram_wr_* outputs are registered.
REQ-019 ram_wr_en SHALL be 0 in any cycle with no accepted transfer or clear write scheduled; addr/data hold their last values.
REQ-020 flush_req in RUN SHALL block acceptance that cycle, and the block SHALL enter CLEAR the next cycle.
REQ-021 A transfer accepted the cycle before a flush_req SHALL still be written, before the first clear write.
REQ-022 flush_req during CLEAR SHALL be ignored; the clear in progress is not restarted.
REQ-023 At most one RAM write per cycle; at most one requester accepted per cycle.

Reset
REQ-024 resetn low SHALL asynchronously force: state=CLEAR, clear_ptr=0, last-served=B, ram_wr_en=0, ram_wr_addr=0, ram_wr_data=0, clear_done=0.
REQ-025 While resetn is low: busy=1 and a_ready=b_ready=0.
REQ-026 The first clear write SHALL occur on the first rising edge after resetn deasserts; reset mid-clear restarts the clear from address 0.

Structure
REQ-027 The state enum (CLEAR, RUN) and the port-index constants (A=0, B=1) SHALL reside in shared package ram_ctrl_pkg.
REQ-028 Round-robin grant logic SHALL be a sub-module rr_arbiter_2 (inputs req[1:0], advance, last-served; output grant[1:0]).

Verification
REQ-029 Deassert reset, wordCount=16: ram_wr_en=1 for 16 consecutive cycles, addr 0..15, data=initValue; busy falls after addr 15; one clear_done pulse.
REQ-030 Both valid continuously after clear (A: addr 3 / data 0xAA, B: addr 5 / data 0x55): accepts A,B,A,B...; each write appears on ram_wr_* one cycle after acceptance.
REQ-031 Only b_valid held high for 4 cycles: B accepted in all 4 cycles; 4 back-to-back writes appear.
REQ-032 A accepted in cycle N, flush_req and a_valid high in N+1: A's N write appears at N+1, no accept at N+1; 16 clear writes start at N+2; next A accept follows busy low.
REQ-033 resetn pulsed low with clear_ptr=7: ram_wr_en drops immediately; after release, the clear restarts at addr 0 and runs the full 16 writes.
REQ-034 wordCount=12, addressWidth=4: the clear issues exactly 12 writes, addr 0..11; no write to addr 12..15.
